// File: rtl/sobel_pixel_packer.sv
// Sobel output stage. It clamps or thresholds each gradient magnitude to 8 bits, packs four
// pixels per 32-bit word in raster order, and queues the words in a 2-entry FIFO with EOL/EOF tags.
module sobel_pixel_packer #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned THRESH = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        i_avg_busy,
  input  logic        i_avg_vld,
  input  logic [31:0] i_avg_data,
  input  logic        o_pix_busy,
  output logic        o_pix_vld,
  output logic [31:0] o_pix_data,
  output logic        o_pix_eol,
  output logic        o_pix_eof,
  output logic [15:0] o_frame_cnt
);

  localparam logic [11:0] ColLast = 12'(WIDTH - 1);
  localparam logic [11:0] RowLast = 12'(HEIGHT - 1);

  logic [11:0] col_q, col_d, row_q, row_d;
  logic [31:0] pack_q, pack_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic        head_eol_q, head_eol_d, head_eof_q, head_eof_d;
  logic        tail_eol_q, tail_eol_d, tail_eof_q, tail_eof_d;
  logic        vld_q, vld_d, busy_q, busy_d;
  logic [15:0] frame_q, frame_d;

  logic [7:0]  clamped, pix;
  logic [1:0]  lane;
  logic [31:0] word;
  logic        accept, pop, push, row_end, frame_end;

  always_comb begin
    clamped = (i_avg_data > 32'd255) ? 8'hFF : i_avg_data[7:0];
    if (THRESH == 0) begin
      pix = clamped;
    end else begin
      pix = ({24'd0, clamped} >= THRESH) ? 8'hFF : 8'h00;
    end
  end

  assign lane      = col_q[1:0];
  assign word      = pack_q | ({24'd0, pix} << {lane, 3'b000});
  assign accept    = i_avg_vld & ~busy_q;
  assign pop       = vld_q & ~o_pix_busy;
  assign row_end   = (col_q == ColLast);
  assign frame_end = row_end & (row_q == RowLast);
  assign push      = accept & ((lane == 2'd3) | row_end);

  // Position tracking and lane packing
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pack_d = pack_q;
    if (accept) begin
      pack_d = push ? 32'd0 : word;
      if (row_end) begin
        col_d = 12'd0;
        row_d = frame_end ? 12'd0 : row_q + 12'd1;
      end else begin
        col_d = col_q + 12'd1;
      end
    end
  end

  // Shift-style FIFO: the head entry is always the output register, so outputs stay registered.
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_eol_d  = head_eol_q;
    head_eof_d  = head_eof_q;
    tail_data_d = tail_data_q;
    tail_eol_d  = tail_eol_q;
    tail_eof_d  = tail_eof_q;
    frame_d     = frame_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_data_d = word;
          head_eol_d  = row_end;
          head_eof_d  = frame_end;
        end else begin
          tail_data_d = word;
          tail_eol_d  = row_end;
          tail_eof_d  = frame_end;
        end
      end
      2'b01: begin
        count_d     = count_q - 2'd1;
        head_data_d = tail_data_q;
        head_eol_d  = tail_eol_q;
        head_eof_d  = tail_eof_q;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = word;
          head_eol_d  = row_end;
          head_eof_d  = frame_end;
        end else begin
          head_data_d = tail_data_q;
          head_eol_d  = tail_eol_q;
          head_eof_d  = tail_eof_q;
          tail_data_d = word;
          tail_eol_d  = row_end;
          tail_eof_d  = frame_end;
        end
      end
      default: ;
    endcase
    if (pop && head_eof_q) begin
      frame_d = frame_q + 16'd1;
    end
    vld_d  = (count_d != 2'd0);
    busy_d = (count_d == 2'd2);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      col_q       <= 12'd0;
      row_q       <= 12'd0;
      pack_q      <= 32'd0;
      count_q     <= 2'd0;
      head_data_q <= 32'd0;
      head_eol_q  <= 1'b0;
      head_eof_q  <= 1'b0;
      tail_data_q <= 32'd0;
      tail_eol_q  <= 1'b0;
      tail_eof_q  <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_q     <= 16'd0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pack_q      <= pack_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_eol_q  <= head_eol_d;
      head_eof_q  <= head_eof_d;
      tail_data_q <= tail_data_d;
      tail_eol_q  <= tail_eol_d;
      tail_eof_q  <= tail_eof_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      frame_q     <= frame_d;
    end
  end

  assign i_avg_busy  = busy_q;
  assign o_pix_vld   = vld_q;
  assign o_pix_data  = head_data_q;
  assign o_pix_eol   = head_eol_q;
  assign o_pix_eof   = head_eof_q;
  assign o_frame_cnt = frame_q;

endmodule
